coreuart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one CoreUART transmitter between up to four byte sources. It sits in front of the transmitter's holding-register interface in the non-FIFO build (TX_FIFO=0). Each byte it accepts from a requester is written with a single load strobe, and it then waits for the transmitter's `txrdy` to return before issuing the next byte. Optional packet lock keeps the grant on one requester until its last byte, with a timeout release.

---
 rtl/coreuart_tx_arb_pkg.sv | 29 ++
 rtl/coreuart_rr_pick.sv | 30 +++
 rtl/coreuart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_coreuart_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coreuart_tx_arb_pkg.sv
// Shared definitions for the CoreUART transmit arbiter: FSM encoding,
// requester limit and a one-hot to index helper.
package coreuart_tx_arb_pkg;

    localparam int MAX_REQ = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STROBE = 3'd2,
        ST_GUARD  = 3'd3,
        ST_GUARD2 = 3'd4
    } arb_state_t;

    // Convert a one-hot requester vector into its index (0 when empty).
    function automatic logic [1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/coreuart_rr_pick.sv
// Combinational round-robin picker: returns the first eligible requester
// found when searching upward from the one after the previous winner.
module coreuart_rr_pick
    import coreuart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [1:0]         i_last_winner,
    output logic [NUM_REQ-1:0] o_winner
);

    logic w_found;
    logic w_hit;

    // Walk the search order once; the first eligible hit becomes the winner.
    always_comb begin
        o_winner = {NUM_REQ{1'b0}};
        w_found  = 1'b0;
        w_hit    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_hit       = (((int'(i_last_winner) + k) % NUM_REQ) == i);
                o_winner[i] = o_winner[i] | (w_hit & i_eligible[i] & ~w_found);
                w_found     = w_found | (w_hit & i_eligible[i]);
            end
        end
    end

endmodule

// File: rtl/coreuart_tx_arbiter.sv
// Round-robin arbiter sharing one CoreUART transmitter holding register
// between up to four byte sources, with optional packet lock and a lock
// timeout that frees the transmitter from a stalled packet owner.
module coreuart_tx_arbiter
    import coreuart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 txrdy,
    output logic [7:0]           tx_data,
    output logic                 tx_load,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 locked,
    output logic                 busy
);

    localparam logic [1:0]  LW_RESET  = 2'(NUM_REQ - 1);
    localparam logic [15:0] TO_LIMIT  = 16'(LOCK_TIMEOUT);
    localparam logic        TO_ENABLE = (LOCK_TIMEOUT != 0);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic               r_locked;
    logic               w_locked_nxt;
    logic [1:0]         r_last_winner;
    logic [1:0]         w_last_winner_nxt;
    logic [7:0]         r_tx_data;
    logic [7:0]         w_tx_data_nxt;
    logic               r_tx_load;
    logic               w_tx_load_nxt;
    logic [15:0]        r_to_cnt;
    logic [15:0]        w_to_cnt_nxt;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_winner;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;
    logic               w_owner_valid;

    // While a packet is locked only its owner may compete.
    always_comb begin
        if (r_locked) begin
            w_eligible = req_valid & r_grant;
        end else begin
            w_eligible = req_valid;
        end
    end

    // Mux the granted requester's byte and last flag (grant is one-hot).
    always_comb begin
        w_sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_data = w_sel_data | (req_data[8*i +: 8] & {8{r_grant[i]}});
        end
        w_sel_last    = |(req_last & r_grant);
        w_owner_valid = |(req_valid & r_grant);
    end

    coreuart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_eligible    (w_eligible),
        .i_last_winner (r_last_winner),
        .o_winner      (w_winner)
    );

    // Next-state and next-register logic for the load/strobe/guard sequence.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_locked_nxt      = r_locked;
        w_last_winner_nxt = r_last_winner;
        w_tx_data_nxt     = r_tx_data;
        w_tx_load_nxt     = 1'b0;
        w_to_cnt_nxt      = r_to_cnt;
        case (r_state)
            ST_IDLE: begin
                if (txrdy && (|w_eligible)) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = ST_LOAD;
                end else if (TO_ENABLE && r_locked && !w_owner_valid) begin
                    // Owner has gone quiet: count towards releasing the lock.
                    if (r_to_cnt == (TO_LIMIT - 16'd1)) begin
                        w_locked_nxt = 1'b0;
                        w_grant_nxt  = {NUM_REQ{1'b0}};
                        w_to_cnt_nxt = 16'd0;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + 16'd1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_tx_data_nxt     = w_sel_data;
                w_locked_nxt      = !w_sel_last;
                w_last_winner_nxt = onehot_to_idx(MAX_REQ'(r_grant));
                w_to_cnt_nxt      = 16'd0;
                w_tx_load_nxt     = 1'b1;
                w_state_nxt       = ST_STROBE;
            end
            ST_STROBE: begin
                w_state_nxt = ST_GUARD;
            end
            ST_GUARD: begin
                w_state_nxt = ST_GUARD2;
            end
            ST_GUARD2: begin
                // Give the transmitter's txrdy time to fall before re-arbitrating.
                w_state_nxt = ST_IDLE;
                if (r_locked) begin
                    w_grant_nxt = r_grant;
                end else begin
                    w_grant_nxt = {NUM_REQ{1'b0}};
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_grant_nxt  = {NUM_REQ{1'b0}};
                w_locked_nxt = 1'b0;
                w_to_cnt_nxt = 16'd0;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= {NUM_REQ{1'b0}};
            r_locked      <= 1'b0;
            r_last_winner <= LW_RESET;
            r_tx_data     <= 8'h00;
            r_tx_load     <= 1'b0;
            r_to_cnt      <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_locked      <= w_locked_nxt;
            r_last_winner <= w_last_winner_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_load     <= w_tx_load_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
        end
    end

    assign req_ready = (r_state == ST_LOAD) ? r_grant : {NUM_REQ{1'b0}};
    assign tx_data   = r_tx_data;
    assign tx_load   = r_tx_load;
    assign grant     = r_grant;
    assign locked    = r_locked;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_coreuart_tx_arbiter.sv
// Bench for coreuart_tx_arbiter (4 requesters, lock timeout 20). A
// transaction-timing model predicts every output each cycle: a grant decided
// in cycle N gives ready at N+1, load/data at N+2, busy N+1..N+4, free at N+5.
module tb_coreuart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 20;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            txrdy;
    logic [7:0]      tx_data;
    logic            tx_load;
    logic [NR-1:0]   grant;
    logic            locked;
    logic            busy;

    always #5 clk = ~clk;

    coreuart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .txrdy(txrdy), .tx_data(tx_data),
        .tx_load(tx_load), .grant(grant), .locked(locked), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // stimulus side: per-requester byte queues {last, data}, transmitter emulation
    logic [8:0] q [NR][$];
    bit         en [NR];
    int         tx_delay;
    int         tx_cnt;
    bit         tx_hold;
    bit         load_seen;
    logic [NR-1:0] pend_pop;
    int         acc_who [$];
    int         acc_cyc [$];

    // model state
    int         cyc;
    int         g_cyc;
    int         m_owner;
    bit         m_locked;
    int         m_last;
    int         m_idle;
    logic [7:0] m_txdata;
    logic [7:0] p_data;
    bit         p_lock;
    logic [18:0] exp_vec;
    logic [18:0] obs_vec;

    task automatic model_reset();
        cyc = 0; g_cyc = -100; m_owner = -1; m_locked = 0;
        m_last = NR - 1; m_idle = 0; m_txdata = 8'h00; p_data = 8'h00; p_lock = 0;
    endtask

    function automatic logic [18:0] model_out();
        logic [3:0] oh;
        logic [3:0] rdy;
        logic [3:0] gnt;
        bit bz;
        bz  = (cyc >= g_cyc + 1) && (cyc <= g_cyc + 4);
        oh  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        rdy = (cyc == g_cyc + 1) ? oh : 4'b0000;
        gnt = (bz || m_locked) ? oh : 4'b0000;
        return {rdy, (cyc == g_cyc + 2), m_txdata, gnt, m_locked, bz};
    endfunction

    task automatic drive_inputs();
        logic [8:0] h;
        for (int i = 0; i < NR; i++) begin
            if (en[i] && q[i].size() > 0) begin
                h = q[i][0];
                req_valid[i] = 1'b1; req_data[8*i +: 8] = h[7:0]; req_last[i] = h[8];
            end else begin
                req_valid[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
            end
        end
        txrdy = !tx_hold && (tx_cnt == 0);
    endtask

    // Advance one clock: model decides on this cycle's inputs, then the DUT
    // outputs of the new cycle are captured next to the model prediction.
    task automatic step();
        int  win;
        bit  found;
        if (cyc >= g_cyc + 5) begin
            found = 0; win = 0;
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (m_last + k) % NR;
                if (!found && req_valid[idx] && (!m_locked || idx == m_owner)) begin
                    found = 1; win = idx;
                end
            end
            if (txrdy && found) begin
                g_cyc = cyc; m_owner = win;
                p_data = req_data[8*win +: 8]; p_lock = !req_last[win];
            end else if (TO > 0 && m_locked && m_owner >= 0 && !req_valid[m_owner]) begin
                m_idle++;
                if (m_idle == TO) begin m_locked = 0; m_idle = 0; end
            end
        end
        @(posedge clk); #1; cyc++;
        if (cyc == g_cyc + 2) begin
            m_txdata = p_data; m_locked = p_lock; m_last = m_owner; m_idle = 0;
        end
        exp_vec = model_out();
        obs_vec = {req_ready, tx_load, tx_data, grant, locked, busy};
        for (int i = 0; i < NR; i++) begin
            if (pend_pop[i] && q[i].size() > 0) void'(q[i].pop_front());
            if (req_ready[i] === 1'b1) begin acc_who.push_back(i); acc_cyc.push_back(cyc); end
        end
        pend_pop = req_ready;
        if (tx_cnt > 0) tx_cnt--;
        if (load_seen) tx_cnt = tx_delay;
        load_seen = (tx_load === 1'b1);
        drive_inputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < NR; i++) begin q[i].delete(); en[i] = 0; end
        tx_hold = 0; tx_cnt = 0; tx_delay = 2; load_seen = 0; pend_pop = '0;
        acc_who.delete(); acc_cyc.delete();
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < NR; i++) begin q[i].delete(); en[i] = 0; end
        tx_hold = 0; tx_cnt = 0; drive_inputs();
        @(negedge clk);
        checks++;
        if ({req_ready, tx_load, tx_data, grant, locked, busy} !== 19'd0)
            $display("FAIL reset_values got=%h expected=0", {req_ready, tx_load, tx_data, grant, locked, busy});
        if ({req_ready, tx_load, tx_data, grant, locked, busy} !== 19'd0) errors++;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_single();
        do_reset();
        q[0].push_back({1'b1, 8'h55}); en[0] = 1; drive_inputs();
        for (int n = 0; n < 10; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL single cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
            if (tx_load === 1'b1) begin
                checks++;
                if (tx_data !== 8'h55 || cyc != 2) begin errors++; $display("FAIL single_load cyc=%0d data=%h expected cyc 2 data 55", cyc, tx_data); end
            end
        end
        checks++;
        if (acc_who.size() != 1 || acc_who[0] != 0 || acc_cyc[0] != 1 || grant !== 4'b0000 || locked !== 1'b0) begin
            errors++; $display("FAIL single_end accepts=%0d grant=%b locked=%b expected 1 accept at cyc 1, grant 0, locked 0", acc_who.size(), grant, locked);
        end
    endtask

    task automatic test_fairness();
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        tx_delay = 10;
        for (int i = 0; i < NR; i++) begin
            en[i] = 1;
            for (int b = 0; b < 8; b++) q[i].push_back({1'b1, 8'($urandom)});
        end
        drive_inputs();
        for (int n = 0; n < 200 && acc_who.size() < 6; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL fairness cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
        end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (acc_who.size() <= j) begin errors++; $display("FAIL fairness_order idx=%0d got=none expected=%0d", j, exp_order[j]); end
            else if (acc_who[j] != exp_order[j]) begin errors++; $display("FAIL fairness_order idx=%0d got=%0d expected=%0d", j, acc_who[j], exp_order[j]); end
        end
    endtask

    task automatic test_lock();
        int exp_order [4] = '{1, 1, 1, 0};
        do_reset();
        tx_delay = 3;
        q[1].push_back({1'b0, 8'hA1}); q[1].push_back({1'b0, 8'hA2}); q[1].push_back({1'b1, 8'hA3});
        for (int b = 0; b < 3; b++) q[0].push_back({1'b1, 8'($urandom)});
        en[1] = 1; drive_inputs();
        for (int n = 0; n < 120 && acc_who.size() < 4; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL lock cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
            if (acc_who.size() >= 1 && !en[0]) begin en[0] = 1; drive_inputs(); end
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (acc_who.size() <= j || acc_who[j] != exp_order[j]) begin
                errors++; $display("FAIL lock_order idx=%0d accepts=%0d expected=%0d", j, acc_who.size(), exp_order[j]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tx_delay = 10;
        q[2].push_back({1'b0, 8'($urandom)}); en[2] = 1;
        q[0].push_back({1'b1, 8'($urandom)});
        drive_inputs();
        for (int n = 0; n < 100 && acc_who.size() < 2; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL timeout cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
            if (acc_who.size() >= 1 && !en[0]) begin en[0] = 1; drive_inputs(); end
        end
        checks++;
        if (acc_who.size() < 2 || acc_who[0] != 2 || acc_who[1] != 0 || (acc_cyc[1] - acc_cyc[0]) != 25) begin
            errors++; $display("FAIL timeout_release accepts=%0d gap=%0d expected 2 then 0 with gap 25", acc_who.size(),
                               (acc_who.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        end
    endtask

    task automatic test_holdoff();
        logic [7:0] b;
        int hits;
        do_reset();
        b = 8'($urandom_range(1, 255));
        q[3].push_back({1'b1, b}); en[3] = 1; tx_delay = 2; drive_inputs();
        for (int n = 0; n < 10; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL holdoff_pre cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
        end
        tx_hold = 1; en[0] = 1; en[1] = 1;
        q[0].push_back({1'b1, 8'h3C}); q[1].push_back({1'b1, 8'hC3}); drive_inputs();
        hits = 0;
        for (int n = 0; n < 15; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL holdoff cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
            if (req_ready !== 4'b0000 || tx_load !== 1'b0) hits++;
            checks++;
            if (tx_data !== b) begin errors++; $display("FAIL holdoff_data cyc=%0d got=%h expected=%h", cyc, tx_data, b); end
        end
        checks++;
        if (hits != 0) begin errors++; $display("FAIL holdoff_quiet got=%0d expected=0", hits); end
        tx_hold = 0; drive_inputs();
        for (int n = 0; n < 60 && acc_who.size() < 3; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL holdoff_post cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
        end
        checks++;
        if (acc_who.size() < 3 || acc_who[1] != 0 || acc_who[2] != 1) begin
            errors++; $display("FAIL holdoff_order accepts=%0d expected 3,0,1", acc_who.size());
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        q[0].push_back({1'b1, 8'($urandom_range(1, 255))}); en[0] = 1; drive_inputs();
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_mid_pre cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
            if (tx_load === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL reset_mid_strobe got=none expected=load"); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, tx_load, tx_data, grant, locked, busy} !== 19'd0) begin
            errors++; $display("FAIL reset_mid_clear got=%h expected=0", {req_ready, tx_load, tx_data, grant, locked, busy});
        end
        do_reset();
        q[1].push_back({1'b1, 8'h11}); q[0].push_back({1'b1, 8'h22});
        en[0] = 1; en[1] = 1; drive_inputs();
        for (int n = 0; n < 30 && acc_who.size() < 2; n++) begin
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_mid_post cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
        end
        checks++;
        if (acc_who.size() < 2 || acc_who[0] != 0 || acc_who[1] != 1) begin
            errors++; $display("FAIL reset_mid_priority accepts=%0d expected 0 then 1", acc_who.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < NR; i++) en[i] = 1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0)
                q[$urandom_range(0, NR - 1)].push_back({($urandom_range(0, 2) != 0), 8'($urandom)});
            tx_delay = $urandom_range(0, 12);
            drive_inputs();
            step(); checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL random cyc=%0d got=%h expected=%h", cyc, obs_vec, exp_vec); end
        end
        checks++;
        if (acc_who.size() < 10) begin errors++; $display("FAIL random_progress got=%0d expected>=10", acc_who.size()); end
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; txrdy = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_timeout();
        test_holdoff();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
